// File: rtl/fft4_pkg.sv
// Shared constants and FSM state type for the 4-point DFT engine.
package fft4_pkg;

  localparam int unsigned FFT_N     = 4;
  localparam int unsigned TW_FRAC   = 16;
  localparam int unsigned RND_CONST = 1 << (TW_FRAC - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fft4_dft_engine_cmac.sv
// Registered complex multiply-accumulate with clear and enable; also exposes
// the combinational next-accumulator value so the last term can be rounded.
module fft4_dft_engine_cmac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 17
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             en,
  input  logic signed [DATA_W-1:0]         a_re,
  input  logic signed [DATA_W-1:0]         a_im,
  input  logic signed [TW_W-1:0]           b_re,
  input  logic signed [TW_W-1:0]           b_im,
  output logic signed [DATA_W+TW_W+2:0]    nxt_re_c,
  output logic signed [DATA_W+TW_W+2:0]    nxt_im_c
);

  localparam int unsigned P_W   = DATA_W + TW_W;
  localparam int unsigned ACC_W = DATA_W + TW_W + 3;

  logic signed [P_W-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_W-1:0] acc_re, acc_im;

  // Operands widened to the product width so the signed multiply cannot clip.
  assign p_rr = P_W'(a_re) * P_W'(b_re);
  assign p_ii = P_W'(a_im) * P_W'(b_im);
  assign p_ri = P_W'(a_re) * P_W'(b_im);
  assign p_ir = P_W'(a_im) * P_W'(b_re);

  assign nxt_re_c = acc_re + ACC_W'(p_rr) - ACC_W'(p_ii);
  assign nxt_im_c = acc_im + ACC_W'(p_ri) + ACC_W'(p_ir);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      acc_re <= nxt_re_c;
      acc_im <= nxt_im_c;
    end
  end

endmodule

// File: rtl/fft4_dft_engine.sv
// Sequential 4-point DFT: buffers a frame, runs one complex MAC per cycle
// against an external twiddle LUT, and streams out rounded bins k = 0..3.
module fft4_dft_engine
  import fft4_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 17,
  parameter int unsigned OUT_W  = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic [1:0]               lut_k,
  output logic [1:0]               lut_n,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic [1:0]               out_k,
  output logic                     out_last
);

  localparam int unsigned ACC_W = DATA_W + TW_W + 3;
  localparam int unsigned SH_W  = ACC_W - TW_FRAC;
  localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(-(64'sd1 <<< (OUT_W - 1)));

  state_t                   state;
  logic [1:0]               cnt, k, n;
  logic signed [DATA_W-1:0] x_re [FFT_N];
  logic signed [DATA_W-1:0] x_im [FFT_N];
  logic signed [ACC_W-1:0]  nxt_re, nxt_im, rnd_re, rnd_im;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [SH_W-1:0] v);
    if (v > SAT_MAX) return OUT_W'(SAT_MAX);
    if (v < SAT_MIN) return OUT_W'(SAT_MIN);
    return OUT_W'(v);
  endfunction

  assign lut_k = k;
  assign lut_n = n;

  // Accumulators sit at zero outside MAC, so each bin starts from a clean sum.
  fft4_dft_engine_cmac #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_cmac (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != MAC),
    .en       (state == MAC),
    .a_re     (x_re[n]),
    .a_im     (x_im[n]),
    .b_re     (tw_re),
    .b_im     (tw_im),
    .nxt_re_c (nxt_re),
    .nxt_im_c (nxt_im)
  );

  // Round half up on the sum that includes the current (last) term.
  assign rnd_re = nxt_re + ACC_W'(RND_CONST);
  assign rnd_im = nxt_im + ACC_W'(RND_CONST);

  // Sample buffer needs no reset: every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      x_re[cnt] <= in_re;
      x_im[cnt] <= in_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      k         <= '0;
      n         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_k     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'(FFT_N - 1)) begin
              state    <= MAC;
              k        <= '0;
              n        <= '0;
              in_ready <= 1'b0;
            end
          end
        end
        MAC: begin
          n <= n + 2'd1;
          if (n == 2'(FFT_N - 1)) begin
            out_re    <= sat(SH_W'(rnd_re >>> TW_FRAC));
            out_im    <= sat(SH_W'(rnd_im >>> TW_FRAC));
            out_k     <= k;
            out_last  <= (k == 2'(FFT_N - 1));
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            n         <= '0;
            if (k == 2'(FFT_N - 1)) begin
              state    <= LOAD;
              cnt      <= '0;
              k        <= '0;
              in_ready <= 1'b1;
            end else begin
              k     <= k + 2'd1;
              state <= MAC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_dft_engine.sv
// Directed bench for fft4_dft_engine: behavioural twiddle LUT, DFT reference
// model feeding a scoreboard, bins checked in order as they are handshaken.
module tb_fft4_dft_engine;

  localparam int DATA_W = 16;
  localparam int TW_W   = 17;
  localparam int OUT_W  = 18;

  // Q1.16 twiddles W^m, m = k*n mod 4
  localparam int TWR [4] = '{65535, 0, -65535, 0};
  localparam int TWI [4] = '{0, -65535, 0, 65535};

  typedef struct {
    longint re;
    longint im;
    int     k;
    int     last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re, in_im;
  logic [1:0]               lut_k, lut_n, m;
  logic signed [TW_W-1:0]   tw_re, tw_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_re, out_im;
  logic [1:0]               out_k;
  logic                     out_last;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t_acc = 0;
  int   fr_re [4];
  int   fr_im [4];
  exp_t sb [$];

  fft4_dft_engine #(.DATA_W(DATA_W), .TW_W(TW_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .lut_k     (lut_k),
    .lut_n     (lut_n),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_k     (out_k),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External twiddle LUT, combinational from the registered address.
  assign m     = lut_k * lut_n;
  assign tw_re = TW_W'(TWR[m]);
  assign tw_im = TW_W'(TWI[m]);

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint rnd_sat(input longint acc);
    longint v;
    v = (acc + 64'sd32768) >>> 16;
    if (v > 131071) v = 131071;
    if (v < -131072) v = -131072;
    return v;
  endfunction

  // Reference DFT of the frame in fr_re/fr_im, one scoreboard entry per bin.
  task automatic push_expected();
    exp_t   e;
    longint ar, ai;
    int     mm;
    for (int kk = 0; kk < 4; kk++) begin
      ar = 0;
      ai = 0;
      for (int nn = 0; nn < 4; nn++) begin
        mm = (kk * nn) % 4;
        ar += longint'(fr_re[nn]) * TWR[mm] - longint'(fr_im[nn]) * TWI[mm];
        ai += longint'(fr_re[nn]) * TWI[mm] + longint'(fr_im[nn]) * TWR[mm];
      end
      e.re   = rnd_sat(ar);
      e.im   = rnd_sat(ai);
      e.k    = kk;
      e.last = (kk == 3) ? 1 : 0;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input string tag);
    int t;
    push_expected();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_re    = DATA_W'(fr_re[i]);
      in_im    = DATA_W'(fr_im[i]);
      t = 0;
      while (!in_ready && t < 60) begin
        tick();
        t++;
      end
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    t_acc    = cyc;
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!out_valid && t < 60) begin
      tick();
      t++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic collect_bin(input string tag, input bit chk_lat);
    exp_t e;
    wait_valid(tag);
    if (chk_lat) check({tag, "_latency"}, 64'(cyc - t_acc), 64'sd4);
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_re"}, 64'($signed(out_re)), e.re);
    check({tag, "_im"}, 64'($signed(out_im)), e.im);
    check({tag, "_k"}, 64'(out_k), 64'(e.k));
    check({tag, "_last"}, 64'(out_last), 64'(e.last));
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic collect_frame(input string tag);
    collect_bin({tag, "_b0"}, 1'b1);
    collect_bin({tag, "_b1"}, 1'b0);
    collect_bin({tag, "_b2"}, 1'b0);
    collect_bin({tag, "_b3"}, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_re", 64'($signed(out_re)), 64'sd0);
    check("rst_out_im", 64'($signed(out_im)), 64'sd0);
    check("rst_out_k", 64'(out_k), 64'd0);
    check("rst_lut_k", 64'(lut_k), 64'd0);
    check("rst_lut_n", 64'(lut_n), 64'd0);
    rst = 1'b0;
    tick();

    // Impulse: flat spectrum, latency to first bin checked.
    fr_re = '{100, 0, 0, 0};
    fr_im = '{0, 0, 0, 0};
    send_frame("imp");
    collect_frame("imp");

    // DC
    fr_re = '{1000, 1000, 1000, 1000};
    fr_im = '{0, 0, 0, 0};
    send_frame("dc");
    collect_frame("dc");

    // Nyquist tone lands in bin 2
    fr_re = '{500, -500, 500, -500};
    fr_im = '{0, 0, 0, 0};
    send_frame("alt");
    collect_frame("alt");

    // Back-pressure on bin 1 of a general complex frame
    fr_re = '{300, 150, -250, 75};
    fr_im = '{-200, 400, 50, -125};
    send_frame("bp");
    collect_bin("bp_b0", 1'b1);
    out_ready = 1'b0;
    wait_valid("bp_stall");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_re", 64'($signed(out_re)), sb[0].re);
      check("bp_hold_im", 64'($signed(out_im)), sb[0].im);
      check("bp_hold_k", 64'(out_k), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    collect_bin("bp_b1", 1'b0);
    collect_bin("bp_b2", 1'b0);
    collect_bin("bp_b3", 1'b0);

    // Full scale; +1.0 is 65535/65536, so X0 lands just under 4*x
    fr_re = '{32767, 32767, 32767, 32767};
    fr_im = '{-32768, -32768, -32768, -32768};
    send_frame("fs");
    collect_frame("fs");

    // Reset after two samples, then a clean impulse frame
    in_valid = 1'b1;
    in_re    = 16'sd7000;
    in_im    = 16'sd1234;
    tick();
    in_re    = -16'sd3000;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_lut_n", 64'(lut_n), 64'd0);
    rst = 1'b0;
    tick();
    fr_re = '{100, 0, 0, 0};
    fr_im = '{0, 0, 0, 0};
    send_frame("rimp");
    collect_frame("rimp");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
